// File: rtl/msrv32_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : msrv32_pc_gen
// Brief    : Program-counter generator with boot, trap/epc/branch redirect and
//            stall-tolerant redirect capture for an AHB instruction fetch port.
// Revision : 1.0 - initial release
// ============================================================================
module msrv32_pc_gen #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   BOOT_ADDRESS = '0,
  parameter bit                C_EXT        = 1'b0
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [1:0]        pc_src_in,
  input  logic [XLEN-1:0]   epc_in,
  input  logic [XLEN-1:0]   trap_address_in,
  input  logic              branch_taken_in,
  input  logic [XLEN-1:1]   iaddr_in,
  input  logic              instr_len2_in,
  input  logic              ahb_ready_in,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   iaddr_out,
  output logic [XLEN-1:0]   pc_plus_step_out,
  output logic              fetch_valid_out,
  output logic              misaligned_instr_out,
  output logic              redirect_pending_out
);

  localparam logic [1:0] C_SRC_BOOT = 2'b00;
  localparam logic [1:0] C_SRC_EPC  = 2'b01;
  localparam logic [1:0] C_SRC_TRAP = 2'b10;
  localparam logic [1:0] C_SRC_SEQ  = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_redir;
  logic              r_redir_trap;
  logic              r_fetch_valid;
  logic              r_pending;

  logic [XLEN-1:0]   w_step;
  logic [XLEN-1:0]   w_pc_plus_step;
  logic [XLEN-1:0]   w_branch_target;
  logic [XLEN-1:0]   w_epc_target;
  logic [XLEN-1:0]   w_trap_target;
  logic              w_misaligned;
  logic              w_branch_ok;
  logic              w_redirect;
  logic [XLEN-1:0]   w_redirect_target;
  logic [XLEN-1:0]   w_run_target;

  assign w_step          = (C_EXT && instr_len2_in) ? XLEN'(2) : XLEN'(4);
  assign w_pc_plus_step  = r_pc + w_step;
  assign w_branch_target = {iaddr_in, 1'b0};
  assign w_trap_target   = {trap_address_in[XLEN-1:2], 2'b00};

  generate
    if (C_EXT) begin : g_epc_cext
      logic w_unused_epc;
      assign w_unused_epc = epc_in[0];
      assign w_epc_target = {epc_in[XLEN-1:1], 1'b0};
    end else begin : g_epc_no_cext
      logic w_unused_epc;
      assign w_unused_epc = ^epc_in[1:0];
      assign w_epc_target = {epc_in[XLEN-1:2], 2'b00};
    end
  endgenerate

  logic w_unused_trap;
  assign w_unused_trap = ^trap_address_in[1:0];

  assign w_misaligned = branch_taken_in && (pc_src_in == C_SRC_SEQ) &&
                        (C_EXT ? 1'b0 : w_branch_target[1]);
  assign w_branch_ok  = branch_taken_in && (pc_src_in == C_SRC_SEQ) && !w_misaligned;
  assign w_redirect   = (pc_src_in == C_SRC_EPC) || (pc_src_in == C_SRC_TRAP) || w_branch_ok;

  always_comb begin
    w_redirect_target = w_branch_target;
    w_run_target      = w_pc_plus_step;
    case (pc_src_in)
      C_SRC_EPC: begin
        w_redirect_target = w_epc_target;
        w_run_target      = w_epc_target;
      end
      C_SRC_TRAP: begin
        w_redirect_target = w_trap_target;
        w_run_target      = w_trap_target;
      end
      default: begin
        // A misaligned taken branch must not move the PC.
        if (w_misaligned)
          w_run_target = r_pc;
        else if (w_branch_ok)
          w_run_target = w_branch_target;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state       <= ST_BOOT;
      r_pc          <= BOOT_ADDRESS;
      r_redir       <= '0;
      r_redir_trap  <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_pending     <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state       <= ST_RUN;
          r_pc          <= BOOT_ADDRESS;
          r_fetch_valid <= 1'b1;
        end
        ST_RUN: begin
          if (pc_src_in == C_SRC_BOOT) begin
            r_pc <= BOOT_ADDRESS;
          end else if (ahb_ready_in) begin
            r_pc <= w_run_target;
          end else if (w_redirect) begin
            r_redir      <= w_redirect_target;
            r_redir_trap <= (pc_src_in == C_SRC_TRAP);
            r_state      <= ST_PEND;
            r_pending    <= 1'b1;
          end
        end
        ST_PEND: begin
          if (pc_src_in == C_SRC_BOOT || ahb_ready_in) begin
            if (pc_src_in == C_SRC_BOOT)
              r_pc <= BOOT_ADDRESS;
            else
              r_pc <= w_redirect ? w_redirect_target : r_redir;
            r_redir      <= '0;
            r_redir_trap <= 1'b0;
            r_state      <= ST_RUN;
            r_pending    <= 1'b0;
          end else if (pc_src_in == C_SRC_TRAP) begin
            r_redir      <= w_trap_target;
            r_redir_trap <= 1'b1;
          end else if (w_redirect && !r_redir_trap) begin
            // A captured trap target outranks later epc/branch requests.
            r_redir <= w_redirect_target;
          end
        end
        default: begin
          r_state       <= ST_BOOT;
          r_fetch_valid <= 1'b0;
          r_pending     <= 1'b0;
        end
      endcase
    end
  end

  assign pc_out               = r_pc;
  assign iaddr_out            = r_pc;
  assign pc_plus_step_out     = w_pc_plus_step;
  assign fetch_valid_out      = r_fetch_valid;
  assign redirect_pending_out = r_pending;
  assign misaligned_instr_out = w_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_msrv32_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_msrv32_pc_gen
// Brief    : Self-checking bench for msrv32_pc_gen (C_EXT=0 and C_EXT=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_msrv32_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pc_src = 2'b11;
  logic [31:0] epc = '0;
  logic [31:0] trap = '0;
  logic        br = 1'b0;
  logic [31:1] iaddr = '0;
  logic        len2 = 1'b0;
  logic        rdy = 1'b1;

  logic [31:0] pc0, ia0, pps0, pc1, ia1, pps1;
  logic        fv0, mis0, pend0, fv1, mis1, pend1;

  always #5 clk = ~clk;

  msrv32_pc_gen #(.XLEN(32), .BOOT_ADDRESS(32'h0), .C_EXT(1'b0)) dut0 (
    .clk_in(clk), .rst_n_in(rst_n), .pc_src_in(pc_src), .epc_in(epc),
    .trap_address_in(trap), .branch_taken_in(br), .iaddr_in(iaddr),
    .instr_len2_in(len2), .ahb_ready_in(rdy), .pc_out(pc0), .iaddr_out(ia0),
    .pc_plus_step_out(pps0), .fetch_valid_out(fv0), .misaligned_instr_out(mis0),
    .redirect_pending_out(pend0));

  msrv32_pc_gen #(.XLEN(32), .BOOT_ADDRESS(32'h0), .C_EXT(1'b1)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .pc_src_in(pc_src), .epc_in(epc),
    .trap_address_in(trap), .branch_taken_in(br), .iaddr_in(iaddr),
    .instr_len2_in(len2), .ahb_ready_in(rdy), .pc_out(pc1), .iaddr_out(ia1),
    .pc_plus_step_out(pps1), .fetch_valid_out(fv1), .misaligned_instr_out(mis1),
    .redirect_pending_out(pend1));

  typedef struct {
    logic [1:0]  src;
    logic        b;
    logic [31:0] tgt;
    logic        r;
    logic [31:0] exp_pc;
    logic        exp_pend;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        pend;
  } exp_t;

  localparam int NV = 23;
  vec_t vecs [NV];
  exp_t sb_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] s, input logic b, input logic [31:0] t,
                              input logic r, input logic [31:0] epcv, input logic pn,
                              input logic ms);
    vec_t v;
    v.src = s; v.b = b; v.tgt = t; v.r = r;
    v.exp_pc = epcv; v.exp_pend = pn; v.exp_mis = ms;
    return v;
  endfunction

  task automatic drive(input logic [1:0] s, input logic b, input logic [31:0] t,
                       input logic r, input logic l2);
    pc_src = s; br = b; iaddr = t[31:1]; epc = t; trap = t; rdy = r; len2 = l2;
  endtask

  logic [31:0] cur_pc;
  exp_t        e;

  initial begin
    // src, br, target, ready, expected pc, expected pending, expected misaligned
    vecs[0]  = mk(2'b11, 0, 32'h0,        1, 32'h4,        0, 0);
    vecs[1]  = mk(2'b11, 0, 32'h0,        1, 32'h8,        0, 0);
    vecs[2]  = mk(2'b11, 1, 32'h40,       1, 32'h40,       0, 0);
    vecs[3]  = mk(2'b11, 1, 32'h102,      1, 32'h40,       0, 1);
    vecs[4]  = mk(2'b01, 0, 32'h307,      1, 32'h304,      0, 0);
    vecs[5]  = mk(2'b10, 0, 32'h1003,     1, 32'h1000,     0, 0);
    vecs[6]  = mk(2'b11, 0, 32'h0,        0, 32'h1000,     0, 0);
    vecs[7]  = mk(2'b11, 1, 32'h100,      0, 32'h1000,     1, 0);
    vecs[8]  = mk(2'b10, 0, 32'h200,      0, 32'h1000,     1, 0);
    vecs[9]  = mk(2'b01, 0, 32'h300,      0, 32'h1000,     1, 0);
    vecs[10] = mk(2'b11, 0, 32'h0,        1, 32'h200,      0, 0);
    vecs[11] = mk(2'b11, 1, 32'h500,      0, 32'h200,      1, 0);
    vecs[12] = mk(2'b01, 0, 32'h600,      0, 32'h200,      1, 0);
    vecs[13] = mk(2'b11, 0, 32'h0,        1, 32'h600,      0, 0);
    vecs[14] = mk(2'b01, 0, 32'h700,      0, 32'h600,      1, 0);
    vecs[15] = mk(2'b11, 1, 32'h800,      1, 32'h800,      0, 0);
    vecs[16] = mk(2'b11, 1, 32'h900,      0, 32'h800,      1, 0);
    vecs[17] = mk(2'b00, 0, 32'h0,        0, 32'h0,        0, 0);
    vecs[18] = mk(2'b11, 0, 32'h0,        1, 32'h4,        0, 0);
    vecs[19] = mk(2'b11, 1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 0);
    vecs[20] = mk(2'b11, 0, 32'h0,        1, 32'h0,        0, 0);
    vecs[21] = mk(2'b11, 0, 32'h0,        1, 32'h4,        0, 0);
    vecs[22] = mk(2'b00, 0, 32'h0,        1, 32'h0,        0, 0);

    // Reset state
    #1;
    chk("rst_pc", pc0, 32'h0);
    chk("rst_fv", {31'b0, fv0}, 32'h0);
    chk("rst_pend", {31'b0, pend0}, 32'h0);
    repeat (2) @(posedge clk);
    #1 chk("rst_hold_fv", {31'b0, fv0}, 32'h0);

    // Release: one BOOT cycle, then RUN at BOOT_ADDRESS
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b11, 0, 32'h0, 1, 0);
    #1;
    chk("boot_fv", {31'b0, fv0}, 32'h0);
    chk("boot_pc", pc0, 32'h0);
    @(posedge clk); #1;
    chk("run_pc", pc0, 32'h0);
    chk("run_fv", {31'b0, fv0}, 32'h1);
    cur_pc = 32'h0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].src, vecs[i].b, vecs[i].tgt, vecs[i].r, 0);
      #1;
      chk($sformatf("v%0d_mis", i), {31'b0, mis0}, {31'b0, vecs[i].exp_mis});
      chk($sformatf("v%0d_pps", i), pps0, cur_pc + 32'h4);
      sb_q.push_back('{pc: vecs[i].exp_pc, pend: vecs[i].exp_pend});
      @(posedge clk); #1;
      e = sb_q.pop_front();
      chk($sformatf("v%0d_pc", i), pc0, e.pc);
      chk($sformatf("v%0d_iaddr", i), ia0, e.pc);
      chk($sformatf("v%0d_pend", i), {31'b0, pend0}, {31'b0, e.pend});
      chk($sformatf("v%0d_fv", i), {31'b0, fv0}, 32'h1);
      cur_pc = e.pc;
    end

    // C_EXT comparison: restart both instances from boot
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; drive(2'b11, 0, 32'h0, 1, 0);
    @(posedge clk); #1;
    @(negedge clk); drive(2'b11, 1, 32'h102, 1, 0);
    #1;
    chk("c0_mis", {31'b0, mis0}, 32'h1);
    chk("c1_mis", {31'b0, mis1}, 32'h0);
    @(posedge clk); #1;
    chk("c0_pc_hold", pc0, 32'h0);
    chk("c1_pc_102", pc1, 32'h102);
    @(negedge clk); drive(2'b11, 0, 32'h0, 1, 1);
    #1;
    chk("c1_pps2", pps1, 32'h104);
    chk("c0_pps4", pps0, 32'h4);
    @(posedge clk); #1;
    chk("c1_pc_104", pc1, 32'h104);
    chk("c0_pc_4", pc0, 32'h4);
    @(negedge clk); drive(2'b01, 0, 32'h307, 1, 0);
    @(posedge clk); #1;
    chk("c1_epc", pc1, 32'h306);
    chk("c0_epc", pc0, 32'h304);

    // Asynchronous reset while a redirect is pending
    @(negedge clk); drive(2'b11, 1, 32'h40, 1, 0);
    @(negedge clk); drive(2'b11, 1, 32'h100, 0, 0);
    @(posedge clk); #1;
    chk("ar_pend_set", {31'b0, pend0}, 32'h1);
    chk("ar_pc_pre", pc0, 32'h40);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_pc", pc0, 32'h0);
    chk("ar_iaddr", ia0, 32'h0);
    chk("ar_pend", {31'b0, pend0}, 32'h0);
    chk("ar_fv", {31'b0, fv0}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
